// File: rtl/dct_pkg.sv
// Shared DCT datapath types: operand/product widths, sign-magnitude records
// and the state encoding used by the sequential sign-magnitude units.
package dct_pkg;

    localparam int MAG_W  = 10;
    localparam int PROD_W = 20;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_operand_t;

    typedef struct packed {
        logic              sign;
        logic [PROD_W-1:0] mag;
    } sm_product_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it did not go negative.
module sm_div_step
    import dct_pkg::*;
#(
    parameter int VW = MAG_W
) (
    input  logic [VW:0]   part_rem,
    input  logic          next_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   new_rem,
    output logic          quot_bit
);

    logic [VW:0] shifted;
    logic [VW:0] trial;

    // The incoming partial remainder is always below the divisor, so its MSB
    // is zero and the shift loses nothing.
    assign shifted  = {part_rem[VW-1:0], next_bit};
    assign trial    = shifted - {1'b0, divisor};
    assign quot_bit = (shifted >= {1'b0, divisor});
    assign new_rem  = quot_bit ? trial : shifted;

endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude restoring divider, one quotient bit per cycle,
// valid/ready handshake on both operand and result sides.
module sm_divider
    import dct_pkg::*;
#(
    parameter int DW = PROD_W,
    parameter int VW = MAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic          dividend_sign,
    input  logic [VW:0]   divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic          quot_sign,
    output logic [VW-1:0] remainder,
    output logic          rem_sign,
    output logic          div_zero
);

    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   rem_q;
    logic [DW-1:0] quo_q;
    logic          qs_q;
    logic          rs_q;

    logic [VW:0]   step_rem;
    logic          step_bit;
    logic [DW-1:0] next_quo;

    sm_div_step #(.VW(VW)) u_step (
        .part_rem (rem_q),
        .next_bit (dvd_q[DW-1]),
        .divisor  (dvs_q),
        .new_rem  (step_rem),
        .quot_bit (step_bit)
    );

    assign next_quo  = {quo_q[DW-2:0], step_bit};
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // NOTE: every register here is sequential state, so all updates use
    // non-blocking assignments; blocking ones would race the step logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            qs_q      <= 1'b0;
            rs_q      <= 1'b0;
            quotient  <= '0;
            quot_sign <= 1'b0;
            remainder <= '0;
            rem_sign  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor[VW-1:0];
                        rem_q <= '0;
                        quo_q <= '0;
                        qs_q  <= dividend_sign ^ divisor[VW];
                        rs_q  <= dividend_sign;
                        if (divisor[VW-1:0] == '0) begin
                            // Negative-zero divisor lands here too: saturate.
                            state     <= S_DONE;
                            quotient  <= '1;
                            quot_sign <= dividend_sign ^ divisor[VW];
                            remainder <= dividend[VW-1:0];
                            rem_sign  <= dividend_sign && (dividend[VW-1:0] != '0);
                            div_zero  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            count <= CW'(DW);
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[DW-2:0], 1'b0};
                    quo_q <= next_quo;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state     <= S_DONE;
                        quotient  <= next_quo;
                        quot_sign <= qs_q && (next_quo != '0);
                        remainder <= step_rem[VW-1:0];
                        rem_sign  <= rs_q && (step_rem[VW-1:0] != '0);
                        div_zero  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
